// File: rtl/vga_console_ctrl.sv
// Character-stream sequencer for the VGA text buffer write port: turns a byte stream
// into glyph writes, backspace blanks, and line/screen clears while tracking the cursor.
module vga_console_ctrl #(
  parameter int          COLS       = 160,
  parameter int          ROWS       = 128,
  parameter int          ADDR_WIDTH = 15,
  parameter logic [7:0]  BLANK      = 8'h20
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CMD_VALID,
  input  logic [7:0]                CMD_CHAR,
  output logic                      CMD_READY,
  output logic [ADDR_WIDTH-1:0]     DATA_ADDR,
  output logic [7:0]                DATA_OUT,
  output logic                      WR_EN,
  output logic [$clog2(COLS)-1:0]   CUR_COL,
  output logic [$clog2(ROWS)-1:0]   CUR_ROW
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [CW-1:0]         LAST_COL    = CW'(COLS - 1);
  localparam logic [RW-1:0]         LAST_ROW    = RW'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A      = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_LINE   = ADDR_WIDTH'(COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_SCREEN = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_SCREEN,
    S_LINE,
    S_IDLE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    ready_q, ready_d;

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [RW-1:0]           adv_row;
  logic [ADDR_WIDTH-1:0]   adv_base;

  // The row base is tracked incrementally so the cursor address needs only an adder.
  assign cur_addr = row_base_q + ADDR_WIDTH'(col_q);
  assign adv_row  = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
  assign adv_base = (row_q == LAST_ROW) ? '0 : row_base_q + COLS_A;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    unique case (state_q)
      S_SCREEN: begin
        wr_en_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = BLANK;
        cnt_d   = cnt_q + ONE_A;
        if (cnt_q == LAST_SCREEN) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_LINE: begin
        wr_en_d = 1'b1;
        addr_d  = row_base_q + cnt_q;
        data_d  = BLANK;
        cnt_d   = cnt_q + ONE_A;
        if (cnt_q == LAST_LINE) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (CMD_VALID) begin
          if (CMD_CHAR inside {[8'h20:8'h7E]}) begin
            wr_en_d = 1'b1;
            addr_d  = cur_addr;
            data_d  = CMD_CHAR;
            if (col_q == LAST_COL) begin
              col_d      = '0;
              row_d      = adv_row;
              row_base_d = adv_base;
              cnt_d      = '0;
              state_d    = S_LINE;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            unique case (CMD_CHAR)
              8'h0A: begin
                col_d      = '0;
                row_d      = adv_row;
                row_base_d = adv_base;
                cnt_d      = '0;
                state_d    = S_LINE;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != '0) begin
                  col_d   = col_q - CW'(1);
                  wr_en_d = 1'b1;
                  addr_d  = cur_addr - ONE_A;
                  data_d  = BLANK;
                end
              end
              8'h0C: begin
                col_d      = '0;
                row_d      = '0;
                row_base_d = '0;
                cnt_d      = '0;
                state_d    = S_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_SCREEN;
      end
    endcase
  end

  // Ready is registered from the next state, so it is high exactly while idle.
  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state_q    <= S_SCREEN;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
    end
  end

  assign CMD_READY = ready_q;
  assign WR_EN     = wr_en_q;
  assign DATA_ADDR = addr_q;
  assign DATA_OUT  = data_q;
  assign CUR_COL   = col_q;
  assign CUR_ROW   = row_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Scoreboard bench for vga_console_ctrl: a cursor model pushes expected buffer writes,
// a negedge monitor pops and compares them, and command tasks check latency and cursor.
module tb_vga_console_ctrl;

  localparam int COLS = 160;
  localparam int ROWS = 128;
  localparam int AW   = 15;
  localparam int WAIT_MAX = 30000;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic [7:0]    CMD_CHAR = 8'h00;
  logic          CMD_READY;
  logic [AW-1:0] DATA_ADDR;
  logic [7:0]    DATA_OUT;
  logic          WR_EN;
  logic [7:0]    CUR_COL;
  logic [6:0]    CUR_ROW;

  vga_console_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .BLANK(8'h20)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_CHAR(CMD_CHAR),
    .CMD_READY(CMD_READY), .DATA_ADDR(DATA_ADDR), .DATA_OUT(DATA_OUT),
    .WR_EN(WR_EN), .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          contig;
    logic          rdy;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_wr_cyc = -10;
  int  exp_col  = 0;
  int  exp_row  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every write outside reset must match the next expected entry.
  always @(negedge CLK) begin
    if (!RESET && WR_EN === 1'b1) begin
      check("wr_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        logic gap_ok;
        e = exp_q.pop_front();
        gap_ok = !e.contig || (cyc == last_wr_cyc + 1);
        check("wr", {gap_ok, CMD_READY, DATA_ADDR, DATA_OUT}, {1'b1, e.rdy, e.addr, e.data});
      end
      last_wr_cyc = cyc;
    end
  end

  task automatic push_line(input int row);
    for (int i = 0; i < COLS; i++)
      exp_q.push_back('{contig: (i > 0), rdy: (i == COLS - 1),
                        addr: AW'(row * COLS + i), data: 8'h20});
  endtask

  task automatic push_screen();
    for (int i = 0; i < COLS * ROWS; i++)
      exp_q.push_back('{contig: (i > 0), rdy: (i == COLS * ROWS - 1),
                        addr: AW'(i), data: 8'h20});
  endtask

  // Drive one byte, apply the model, wait for acceptance, then check the cycle after.
  task automatic send(input logic [7:0] c);
    bit wr_now = 0;
    bit clr = 0;
    int n = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      wr_now = 1;
      exp_q.push_back('{contig: 1'b0, rdy: (exp_col != COLS - 1),
                        addr: AW'(exp_row * COLS + exp_col), data: c});
      if (exp_col == COLS - 1) begin
        exp_col = 0;
        exp_row = (exp_row + 1) % ROWS;
        clr = 1;
        push_line(exp_row);
      end else begin
        exp_col++;
      end
    end else if (c == 8'h0A) begin
      exp_col = 0;
      exp_row = (exp_row + 1) % ROWS;
      clr = 1;
      push_line(exp_row);
    end else if (c == 8'h0D) begin
      exp_col = 0;
    end else if (c == 8'h08) begin
      if (exp_col > 0) begin
        exp_col--;
        wr_now = 1;
        exp_q.push_back('{contig: 1'b0, rdy: 1'b1,
                          addr: AW'(exp_row * COLS + exp_col), data: 8'h20});
      end
    end else if (c == 8'h0C) begin
      exp_col = 0;
      exp_row = 0;
      clr = 1;
      push_screen();
    end
    CMD_VALID = 1'b1;
    CMD_CHAR  = c;
    while (CMD_READY !== 1'b1 && n < WAIT_MAX) begin
      @(posedge CLK); #1;
      n++;
    end
    check("ready_wait", 64'(CMD_READY), 64'd1);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    check("cmd_wr", 64'(WR_EN), 64'(wr_now));
    check("cursor", {CUR_ROW, CUR_COL}, {7'(exp_row), 8'(exp_col)});
    check("ready_after", 64'(CMD_READY), 64'(!clr));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < WAIT_MAX) begin
      @(posedge CLK); #1;
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #(10 * 98000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges, then the full screen clear.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_outs", {CMD_READY, WR_EN, DATA_ADDR, DATA_OUT, CUR_COL, CUR_ROW}, 64'd0);
    push_screen();
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("first_clr_wr", {WR_EN, DATA_ADDR}, {1'b1, 15'd0});
    drain("init_clear_done");
    check("init_ready_cursor", {CMD_READY, CUR_ROW, CUR_COL}, {1'b1, 7'd0, 8'd0});

    // Back-to-back A, B, CR, C.
    send(8'h41);
    send(8'h42);
    send(8'h0D);
    send(8'h43);
    check("abc_col", 64'(CUR_COL), 64'd1);

    // Move to col 5, then LF with CMD_VALID held through the line clear.
    send(8'h62); send(8'h63); send(8'h64); send(8'h65);
    send(8'h0A);
    send(8'h58);
    drain("lf_done");

    // Backspace at col 0, at (3,2), and an ignored control byte.
    send(8'h0D);
    send(8'h08);
    send(8'h0A);
    send(8'h61); send(8'h62); send(8'h63);
    send(8'h08);
    check("bs_col", 64'(CUR_COL), 64'd2);
    send(8'h01);
    drain("bs_done");

    // Walk to (159,127) and wrap with a printable.
    for (int i = 0; i < 125; i++) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send(8'h71);
    check("pre_wrap_cursor", {CUR_ROW, CUR_COL}, {7'd127, 8'd159});
    send(8'h5A);
    drain("wrap_done");

    // Form feed.
    send(8'h77);
    send(8'h0C);
    drain("ff_done");

    // Reset pulse on the 50th write of a line clear.
    send(8'h0A);
    begin
      int n = 0;
      while (!(WR_EN === 1'b1 && exp_q.size() == COLS - 49) && n < 500) begin
        @(posedge CLK); #1;
        n++;
      end
      check("lc50_addr", 64'(DATA_ADDR), 64'(COLS + 49));
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_outs", {CMD_READY, WR_EN, CUR_COL, CUR_ROW}, 64'd0);
    @(posedge CLK); #1;
    check("rst_mid_wr_en", 64'(WR_EN), 64'd0);
    exp_q.delete();
    exp_col = 0;
    exp_row = 0;
    push_screen();
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("restart_wr", {WR_EN, DATA_ADDR}, {1'b1, 15'd0});
    drain("restart_done");
    check("restart_cursor", {CMD_READY, CUR_ROW, CUR_COL}, {1'b1, 7'd0, 8'd0});

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_console_ctrl.md
# vga_console_ctrl

Character-stream sequencer for the VGA text-mode character buffer write port. Accepts one byte at a time over a valid/ready handshake, keeps a text cursor, and turns each byte into buffer writes: glyph store, line clear on newline/wrap, full-screen clear on reset and form-feed. Its outputs connect directly to `DATA_ADDR`/`DATA_IN`/`WR_EN` of the `vga` top, on the same pixel-clock domain.

## Interface
- `COLS`, 160: text columns (1280 / 8).
- `ROWS`, 128: text rows (1024 / 8).
- `ADDR_WIDTH`, 15: buffer address width; must satisfy 2^ADDR_WIDTH ≥ COLS*ROWS.
- `BLANK`, 8'h20: fill character for clears.
- `CLK` in 1: clock (pixel clock). One clock domain only.
- `RESET` in 1: reset, synchronous, active-high.
- `CMD_VALID` in 1: `CMD_CHAR` is valid.
- `CMD_CHAR` in 8: character/control byte.
- `CMD_READY` out 1: registered; 1 exactly when the FSM is in IDLE.
- `DATA_ADDR` out ADDR_WIDTH: buffer write address, row*COLS+col.
- `DATA_OUT` out 8: buffer write data.
- `WR_EN` out 1: buffer write strobe, one write per cycle high.
- `CUR_COL` out $clog2(COLS): cursor column.
- `CUR_ROW` out $clog2(ROWS): cursor row.

## Operation
- FSM states:
  - SCREEN_CLEAR: writes BLANK to addresses 0..COLS*ROWS-1 ascending, one per cycle, then goes to IDLE.
  - LINE_CLEAR: writes BLANK to row_base..row_base+COLS-1 ascending, then goes to IDLE.
  - IDLE: accepts commands.
- Accept = `CMD_VALID` & `CMD_READY` at a rising edge. Not accepted while `CMD_READY`=0; the source holds `CMD_CHAR` stable until accepted.
- Command decode (in IDLE):
  - 0x20–0x7E printable: write the char at cursor, then col+1. If col was COLS-1: col→0, row advances, go to LINE_CLEAR for the new row.
  - 0x0A LF: col→0, row advances, go to LINE_CLEAR for the new row.
  - 0x0D CR: col→0, no write.
  - 0x08 BS: if col>0, col-1 and write BLANK at the new position. If col=0, no-op.
  - 0x0C FF: cursor→(0,0), go to SCREEN_CLEAR.
  - Any other byte: accepted and discarded, no write, no cursor change.
- Row advance: row+1, and row_base += COLS. Row ROWS-1 wraps to row 0 with row_base 0. No scrolling; the wrapped-to line is cleared instead.
- Address arithmetic:
  - row_base is held in a register, so no multiplier.
  - `DATA_ADDR` = row_base + col, zero-extended to ADDR_WIDTH.
  - The clear counter runs 0..COLS-1 (line) or 0..COLS*ROWS-1 (screen).

## Timing
- While `RESET`=1 at an edge, all outputs become 0: `WR_EN`, `DATA_ADDR`, `DATA_OUT`, `CMD_READY`, `CUR_COL`, `CUR_ROW`. The FSM goes to SCREEN_CLEAR with counter 0.
- Reset mid-operation: aborts any clear or write and restarts the full screen clear. Cursor returns to (0,0).
- All outputs are registered. A command accepted at edge N drives its write (`WR_EN`=1, address, data) in cycle N+1. The cursor outputs update in cycle N+1.
- Printable without wrap, CR, BS, ignored bytes: `CMD_READY` stays 1. Throughput is one byte per cycle.
- Clear entered at edge N (wrap, LF, FF):
  - `CMD_READY`=0 from cycle N+1.
  - Clear writes occupy cycles N+2 .. N+1+COLS (line) or N+2 .. N+1+COLS*ROWS (screen), contiguous.
  - On wrap, the glyph write occupies cycle N+1. For LF/FF, `WR_EN`=0 in cycle N+1.
  - `CMD_READY` returns to 1 in the same cycle as the last clear write, so a new command can be accepted at the end of that cycle.
- After reset release, the first clear write occurs in the cycle following the first edge with `RESET`=0. `CMD_READY` rises with write COLS*ROWS-1.
- `WR_EN` is never high for more than one address per cycle. `DATA_ADDR`/`DATA_OUT` values are don't-care when `WR_EN`=0, but hold their last value.

## Test plan
- Reset: hold `RESET` 3 cycles, then release → `WR_EN`=1 for exactly 20480 consecutive cycles. `DATA_ADDR` runs 0..20479, `DATA_OUT`=0x20. `CMD_READY` rises with address 20479. Cursor is (0,0).
- Back-to-back 0x41, 0x42, 0x0D, 0x43 from (0,0) → writes addr0=0x41, addr1=0x42 in consecutive cycles, no write for the CR, then addr0=0x43. `CMD_READY` is constantly 1. Final `CUR_COL`=1.
- LF at (col 5, row 0) → cursor becomes (0,1). 160 writes of 0x20 to addr 160..319. `CMD_READY`=0 until the cycle of addr 319. `CMD_VALID` held high during this window is not accepted.
- Wrap: printable 0x5A at (159,127) → write addr 20479=0x5A, cursor becomes (0,0), then 160 blank writes to addr 0..159.
- BS at col 0 → no write, cursor unchanged. BS at (3,2) → write 0x20 to addr 322, `CUR_COL`=2. Byte 0x01 → no write, cursor unchanged.
- `RESET` pulsed during the 50th write of a line clear → `WR_EN`=0 while `RESET` is high. Then a full 20480-write screen clear restarts from addr 0, and the cursor is (0,0).
